// File: rtl/fmap_weight_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmap_weight_buffer: feature-map scratchpad with 3x3 window read ports and  |
// | a weight-channel loader.                            Revision: 1.0          |
// +----------------------------------------------------------------------------+
module fmap_weight_buffer #(
  parameter int WIDTH  = 57,
  parameter int HEIGHT = 8,
  parameter int WB     = 6,
  parameter int HB     = 3,
  parameter int NPORT  = 9,
  parameter int NCH    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [WB-1:0]               wr_w,
  input  logic [HB-1:0]               wr_h,
  input  logic [8*NPORT-1:0]          wr_data,
  input  logic                        rd_en,
  input  logic [WB*NPORT-1:0]         rd_w,
  input  logic [HB*NPORT-1:0]         rd_h,
  output logic [8*NPORT-1:0]          fmap,
  output logic                        fmap_valid,
  input  logic                        wt_en,
  input  logic                        wt_clr,
  input  logic [8*NPORT-1:0]          wt_data,
  output logic [8*NPORT*NCH-1:0]      weight,
  output logic                        weight_ready
);

  localparam int               c_chb      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WB:0]      c_width    = (WB+1)'(WIDTH);
  localparam logic [HB:0]      c_height   = (HB+1)'(HEIGHT);
  localparam logic [c_chb-1:0] c_last_ch  = c_chb'(NCH-1);
  localparam logic [1:0]       c_st_idle  = 2'd0;
  localparam logic [1:0]       c_st_load  = 2'd1;
  localparam logic [1:0]       c_st_ready = 2'd2;

  // Full power-of-two array keeps address widths exact; entries past WIDTH/HEIGHT are never written.
  logic [7:0]         r_mem [2**WB][2**HB];
  logic [WB:0]        w_wr_col [NPORT];
  logic [NPORT-1:0]   w_wr_ok;
  logic [WB-1:0]      w_rd_col [NPORT];
  logic [HB-1:0]      w_rd_row [NPORT];
  logic [NPORT-1:0]   w_rd_ok;
  logic [7:0]         r_fmap [NPORT];
  logic               r_fmap_valid;
  logic [1:0]         r_state;
  logic [c_chb-1:0]   r_ch;
  logic [8*NPORT-1:0] r_wt [NCH];

  generate
    for (genvar k = 0; k < NPORT; k++) begin : g_port
      assign w_wr_col[k] = {1'b0, wr_w} + (WB+1)'(k);
      assign w_wr_ok[k]  = wr_en && ({1'b0, wr_h} < c_height) && (w_wr_col[k] < c_width);
      assign w_rd_col[k] = rd_w[WB*(NPORT-k)-1 -: WB];
      assign w_rd_row[k] = rd_h[HB*(NPORT-k)-1 -: HB];
      assign w_rd_ok[k]  = ({1'b0, w_rd_col[k]} < c_width) && ({1'b0, w_rd_row[k]} < c_height);
      assign fmap[8*(NPORT-k)-1 -: 8] = r_fmap[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (w_wr_ok[k]) begin
        r_mem[w_wr_col[k][WB-1:0]][wr_h] <= wr_data[8*(NPORT-k)-1 -: 8];
      end
    end
  end

  // Reads sample r_mem before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NPORT; k++) r_fmap[k] <= 8'h00;
      r_fmap_valid <= 1'b0;
    end else begin
      r_fmap_valid <= rd_en;
      if (rd_en) begin
        for (int k = 0; k < NPORT; k++) begin
          r_fmap[k] <= w_rd_ok[k] ? r_mem[w_rd_col[k]][w_rd_row[k]] : 8'h00;
        end
      end
    end
  end

  assign fmap_valid = r_fmap_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_ch    <= '0;
      for (int c = 0; c < NCH; c++) r_wt[c] <= '0;
    end else if (wt_clr) begin
      r_state <= c_st_idle;
      r_ch    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (wt_en) begin
            r_wt[0] <= wt_data;
            if (NCH == 1) begin
              r_state <= c_st_ready;
            end else begin
              r_ch    <= c_chb'(1);
              r_state <= c_st_load;
            end
          end
        end
        c_st_load: begin
          if (wt_en) begin
            r_wt[r_ch] <= wt_data;
            if (r_ch == c_last_ch) begin
              r_state <= c_st_ready;
              r_ch    <= '0;
            end else begin
              r_ch <= r_ch + c_chb'(1);
            end
          end
        end
        c_st_ready: ;
        default: r_state <= c_st_idle;
      endcase
    end
  end

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_wt
      assign weight[8*NPORT*(NCH-c)-1 -: 8*NPORT] = r_wt[c];
    end
  endgenerate

  assign weight_ready = (r_state == c_st_ready);

endmodule
`default_nettype wire

// File: tb/tb_fmap_weight_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fmap_weight_buffer: randomized bench with a behavioural buffer model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fmap_weight_buffer;

  localparam int WIDTH  = 57;
  localparam int HEIGHT = 8;
  localparam int WB     = 6;
  localparam int HB     = 4;   // one spare row bit so rows >= HEIGHT can be driven
  localparam int NPORT  = 9;
  localparam int NCH    = 8;
  localparam int BW     = 8*NPORT;

  logic                clk;
  logic                reset;
  logic                wr_en;
  logic [WB-1:0]       wr_w;
  logic [HB-1:0]       wr_h;
  logic [BW-1:0]       wr_data;
  logic                rd_en;
  logic [WB*NPORT-1:0] rd_w;
  logic [HB*NPORT-1:0] rd_h;
  logic [BW-1:0]       fmap;
  logic                fmap_valid;
  logic                wt_en;
  logic                wt_clr;
  logic [BW-1:0]       wt_data;
  logic [BW*NCH-1:0]   weight;
  logic                weight_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0]    mdl [WIDTH][HEIGHT];
  logic [BW-1:0] wexp [NCH];
  int            wcnt;
  bit            wready;
  logic [BW-1:0] exp_fmap;
  bit            exp_valid;

  fmap_weight_buffer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WB(WB), .HB(HB), .NPORT(NPORT), .NCH(NCH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_w(wr_w), .wr_h(wr_h), .wr_data(wr_data),
    .rd_en(rd_en), .rd_w(rd_w), .rd_h(rd_h),
    .fmap(fmap), .fmap_valid(fmap_valid),
    .wt_en(wt_en), .wt_clr(wt_clr), .wt_data(wt_data),
    .weight(weight), .weight_ready(weight_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_read(int w, int h);
    if (w < WIDTH && h < HEIGHT) return mdl[w][h];
    return 8'h00;
  endfunction

  function automatic void m_write(int w, int h, logic [BW-1:0] d);
    if (h >= HEIGHT) return;
    for (int k = 0; k < NPORT; k++)
      if (w + k < WIDTH) mdl[w+k][h] = d[8*(NPORT-1-k) +: 8];
  endfunction

  function automatic logic [BW-1:0] exp_read();
    logic [BW-1:0] e;
    for (int k = 0; k < NPORT; k++)
      e[8*(NPORT-1-k) +: 8] = m_read(int'(rd_w[WB*(NPORT-1-k) +: WB]), int'(rd_h[HB*(NPORT-1-k) +: HB]));
    return e;
  endfunction

  function automatic logic [BW*NCH-1:0] exp_weight();
    logic [BW*NCH-1:0] e;
    for (int c = 0; c < NCH; c++) e[BW*(NCH-1-c) +: BW] = wexp[c];
    return e;
  endfunction

  function automatic void model_reset();
    exp_fmap  = '0;
    exp_valid = 1'b0;
    for (int c = 0; c < NCH; c++) wexp[c] = '0;
    wcnt   = 0;
    wready = 1'b0;
  endfunction

  task automatic put_rd(int k, int w, int h);
    rd_w[WB*(NPORT-1-k) +: WB] = WB'(w);
    rd_h[HB*(NPORT-1-k) +: HB] = HB'(h);
  endtask

  // Advance the model by the inputs currently driven, then one clock.
  task automatic tick();
    if (rd_en) exp_fmap = exp_read();
    exp_valid = rd_en;
    if (wr_en) m_write(int'(wr_w), int'(wr_h), wr_data);
    if (wt_clr) begin
      wcnt   = 0;
      wready = 1'b0;
    end else if (wt_en && !wready) begin
      wexp[wcnt] = wt_data;
      wcnt++;
      if (wcnt == NCH) begin
        wready = 1'b1;
        wcnt   = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 0; rd_en = 0; wt_en = 0; wt_clr = 0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (fmap !== '0) begin bad++; $display("FAIL reset_fmap got=%h want=0", fmap); end
    total++; if (fmap_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", fmap_valid); end
    total++; if (weight !== '0) begin bad++; $display("FAIL reset_weight got=%h want=0", weight); end
    total++; if (weight_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", weight_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w += NPORT) begin
        wr_en = 1; wr_w = WB'(w); wr_h = HB'(h);
        wr_data = {$urandom, $urandom, $urandom};
        tick();
      end
    idle_inputs();
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_w = 0; wr_h = 2; wr_data = 72'h010203040506070809;
    tick();
    wr_en = 0; rd_en = 1;
    for (int k = 0; k < NPORT; k++) put_rd(k, k, 2);
    tick();
    total++; if (fmap !== 72'h010203040506070809) begin bad++; $display("FAIL wr_rd_data got=%h want=010203040506070809", fmap); end
    total++; if (fmap_valid !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b want=1", fmap_valid); end
    rd_en = 0;
    tick();
    total++; if (fmap_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", fmap_valid); end
    total++; if (fmap !== 72'h010203040506070809) begin bad++; $display("FAIL idle_hold got=%h want=010203040506070809", fmap); end
  endtask

  task automatic test_clip();
    logic [BW-1:0] d;
    d = {$urandom, $urandom, $urandom};
    wr_en = 1; wr_w = 52; wr_h = 0; wr_data = d;
    tick();
    wr_en = 1; wr_w = 0; wr_h = 9; wr_data = {$urandom, $urandom, $urandom};  // whole write dropped
    tick();
    wr_en = 0; rd_en = 1;
    put_rd(0, 57, 0); put_rd(1, 0, 8); put_rd(2, 56, 0); put_rd(3, 52, 0);
    put_rd(4, 63, 15); put_rd(5, 0, 1); put_rd(6, 1, 1); put_rd(7, 8, 1); put_rd(8, 53, 0);
    tick();
    total++; if (fmap[71:64] !== 8'h00) begin bad++; $display("FAIL pad_col got=%h want=00", fmap[71:64]); end
    total++; if (fmap[63:56] !== 8'h00) begin bad++; $display("FAIL pad_row got=%h want=00", fmap[63:56]); end
    total++; if (fmap[55:48] !== d[39:32]) begin bad++; $display("FAIL clip_col56 got=%h want=%h", fmap[55:48], d[39:32]); end
    total++; if (fmap !== exp_fmap) begin bad++; $display("FAIL clip_all got=%h want=%h", fmap, exp_fmap); end
    rd_en = 0;
  endtask

  task automatic test_read_first();
    wr_en = 1; wr_w = 3; wr_h = 1; wr_data = {8'hAA, 64'(({$urandom, $urandom}))};
    tick();
    wr_data = {8'hBB, wr_data[63:0]};
    rd_en = 1;
    for (int k = 0; k < NPORT; k++) put_rd(k, 3, 1);
    tick();
    total++; if (fmap[71:64] !== 8'hAA) begin bad++; $display("FAIL rf_old got=%h want=AA", fmap[71:64]); end
    wr_en = 0;
    tick();
    total++; if (fmap[71:64] !== 8'hBB) begin bad++; $display("FAIL rf_new got=%h want=BB", fmap[71:64]); end
    rd_en = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      wr_en   = 1'($urandom);
      wr_w    = WB'($urandom_range(0, 63));
      wr_h    = HB'($urandom_range(0, 9));
      wr_data = {$urandom, $urandom, $urandom};
      rd_en   = 1'($urandom);
      for (int k = 0; k < NPORT; k++) put_rd(k, $urandom_range(0, 63), $urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) put_rd(0, int'(wr_w), int'(wr_h));
      tick();
      total++; if (fmap_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b want=%b", i, fmap_valid, exp_valid); end
      total++; if (fmap !== exp_fmap) begin bad++; $display("FAIL rnd_fmap i=%0d got=%h want=%h", i, fmap, exp_fmap); end
    end
    idle_inputs();
  endtask

  task automatic test_weight_load();
    wt_clr = 1;
    tick();
    wt_clr = 0;
    for (int c = 0; c < NCH; c++) begin
      wt_en = 1; wt_data = {NPORT{8'(c + 1)}};
      tick();
      total++; if (weight_ready !== (c == NCH - 1)) begin bad++; $display("FAIL wt_ready beat=%0d got=%b want=%b", c + 1, weight_ready, (c == NCH - 1)); end
      total++; if (weight !== exp_weight()) begin bad++; $display("FAIL wt_data beat=%0d got=%h want=%h", c + 1, weight, exp_weight()); end
    end
    total++; if (weight[BW*NCH-1 -: BW] !== {NPORT{8'h01}}) begin bad++; $display("FAIL wt_ch0 got=%h want=%h", weight[BW*NCH-1 -: BW], {NPORT{8'h01}}); end
    wt_data = {$urandom, $urandom, $urandom};
    tick();
    total++; if (weight !== exp_weight()) begin bad++; $display("FAIL wt_ignore got=%h want=%h", weight, exp_weight()); end
    total++; if (weight_ready !== 1'b1) begin bad++; $display("FAIL wt_ignore_ready got=%b want=1", weight_ready); end
    wt_en = 0;
  endtask

  task automatic test_clear();
    wt_clr = 1;
    tick();
    total++; if (weight_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b want=0", weight_ready); end
    total++; if (weight !== exp_weight()) begin bad++; $display("FAIL clr_keep got=%h want=%h", weight, exp_weight()); end
    wt_clr = 0;
    for (int c = 0; c < 3; c++) begin
      wt_en = 1; wt_data = {NPORT{8'(8'hC0 + c)}};
      tick();
    end
    wt_clr = 1; wt_en = 1; wt_data = {NPORT{8'hEE}};
    tick();
    total++; if (weight_ready !== 1'b0) begin bad++; $display("FAIL clrpri_ready got=%b want=0", weight_ready); end
    total++; if (weight !== exp_weight()) begin bad++; $display("FAIL clrpri_data got=%h want=%h", weight, exp_weight()); end
    wt_clr = 0; wt_data = {NPORT{8'h5A}};
    tick();
    total++; if (weight[BW*NCH-1 -: BW] !== {NPORT{8'h5A}}) begin bad++; $display("FAIL clr_restart got=%h want=%h", weight[BW*NCH-1 -: BW], {NPORT{8'h5A}}); end
    total++; if (weight !== exp_weight()) begin bad++; $display("FAIL clr_restart_all got=%h want=%h", weight, exp_weight()); end
    wt_en = 0;
  endtask

  task automatic test_async_reset();
    wt_clr = 1;
    tick();
    wt_clr = 0;
    rd_en = 1;
    for (int k = 0; k < NPORT; k++) put_rd(k, k, 2);
    wt_en = 1; wt_data = {NPORT{8'h77}};
    tick();
    rd_en = 0; wt_data = {NPORT{8'h78}};
    tick();
    idle_inputs();
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++; if (fmap !== '0) begin bad++; $display("FAIL areset_fmap got=%h want=0", fmap); end
    total++; if (fmap_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", fmap_valid); end
    total++; if (weight !== '0) begin bad++; $display("FAIL areset_weight got=%h want=0", weight); end
    total++; if (weight_ready !== 1'b0) begin bad++; $display("FAIL areset_ready got=%b want=0", weight_ready); end
    @(negedge clk);
    reset = 1'b1;
    rd_en = 1;
    for (int k = 0; k < NPORT; k++) put_rd(k, k, 2);
    tick();
    total++; if (fmap !== exp_fmap) begin bad++; $display("FAIL areset_mem got=%h want=%h", fmap, exp_fmap); end
    rd_en = 0; wt_en = 1; wt_data = {NPORT{8'h33}};
    tick();
    total++; if (weight !== exp_weight()) begin bad++; $display("FAIL areset_reload got=%h want=%h", weight, exp_weight()); end
    total++; if (weight_ready !== 1'b0) begin bad++; $display("FAIL areset_reload_ready got=%b want=0", weight_ready); end
    wt_en = 0;
  endtask

  initial begin
    reset = 1'b1;
    wr_w = '0; wr_h = '0; wr_data = '0; rd_w = '0; rd_h = '0; wt_data = '0;
    idle_inputs();
    model_reset();
    for (int w = 0; w < WIDTH; w++)
      for (int h = 0; h < HEIGHT; h++) mdl[w][h] = 8'h00;
    #1 reset = 1'b0;
    test_reset();
    fill_mem();
    test_write_read();
    test_clip();
    test_read_first();
    test_random();
    test_weight_load();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
